// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: nibble width and
// active-low glyph patterns (bit6 = g ... bit0 = a).
package seven_seg_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  function automatic logic [6:0] glyph_of(input logic [NIBBLE_W-1:0] n);
    case (n)
      4'h0:    return GLYPH_0;
      4'h1:    return GLYPH_1;
      4'h2:    return GLYPH_2;
      4'h3:    return GLYPH_3;
      4'h4:    return GLYPH_4;
      4'h5:    return GLYPH_5;
      4'h6:    return GLYPH_6;
      4'h7:    return GLYPH_7;
      4'h8:    return GLYPH_8;
      4'h9:    return GLYPH_9;
      4'hA:    return GLYPH_A;
      4'hB:    return GLYPH_B;
      4'hC:    return GLYPH_C;
      4'hD:    return GLYPH_D;
      4'hE:    return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Nibble-to-glyph decoder; nibbles 10-15 decode only in hex mode.
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                hex_mode,
  input  logic                blank,
  output logic [6:0]          pattern
);

  always_comb begin
    pattern = GLYPH_BLANK;
    if (!blank && (hex_mode || (nibble < 4'd10)))
      pattern = glyph_of(nibble);
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode seven-segment driver with double-buffered value,
// guard time, leading-zero blanking and per-digit blinking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                         load,
  input  logic                         hex_mode,
  input  logic                         lz_blank,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  output logic [6:0]                   segments,
  output logic [NUM_DIGITS-1:0]        digit_en,
  output logic                         frame_done
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] LAST_FC  = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]                   cnt;
  logic [IW-1:0]                   idx;
  logic [FW-1:0]                   fc;
  logic                            phase;
  logic [NIBBLE_W*NUM_DIGITS-1:0]  display, pending;
  logic                            pending_valid;

  logic                  slot_end, frame_end;
  logic [NUM_DIGITS-1:0] hz;
  logic [NIBBLE_W-1:0]   nib;
  logic                  blank;
  logic [NUM_DIGITS-1:0] en_n;
  logic [6:0]            pattern;

  assign slot_end  = (cnt == LAST_CNT);
  assign frame_end = slot_end && (idx == LAST_IDX);

  // hz[k]: display nibbles k..NUM_DIGITS-1 are all zero
  always_comb begin
    hz    = '0;
    nib   = '0;
    blank = 1'b0;
    en_n  = '1;
    hz[NUM_DIGITS-1] = (display[NIBBLE_W*(NUM_DIGITS-1) +: NIBBLE_W] == '0);
    for (int unsigned k = NUM_DIGITS - 1; k > 0; k--)
      hz[k-1] = hz[k] && (display[NIBBLE_W*(k-1) +: NIBBLE_W] == '0);
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib     = display[NIBBLE_W*k +: NIBBLE_W];
        blank   = (lz_blank && (k != 0) && hz[k]) || (phase && blink_mask[k]);
        en_n[k] = 1'b0;
      end
    end
  end

  seven_seg_glyph u_glyph (
    .nibble   (nib),
    .hex_mode (hex_mode),
    .blank    (blank),
    .pattern  (pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      fc            <= '0;
      phase         <= 1'b0;
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      segments      <= GLYPH_BLANK;
      digit_en      <= '1;
      frame_done    <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (frame_end) begin
        if (fc == LAST_FC) begin
          fc    <= '0;
          phase <= ~phase;
        end else begin
          fc <= fc + 1'b1;
        end
        if (pending_valid) begin
          display       <= pending;
          pending_valid <= 1'b0;
        end
      end
      // A load in the commit cycle wins pending and re-arms it for the next frame
      if (load) begin
        pending       <= value;
        pending_valid <= 1'b1;
      end
      frame_done <= frame_end;
      if (cnt >= GUARD_C) begin
        digit_en <= en_n;
        segments <= pattern;
      end else begin
        digit_en <= '1;
        segments <= GLYPH_BLANK;
      end
    end
  end

endmodule
